// File: rtl/disp_regctrl_pkg.sv
// Shared constants and byte-enable helpers for the display layer register controller.
//   Register byte offsets (12-bit, block-relative), bit indices inside INTCTRL,
//   UPDCTRL, DISPCTRL and FIFOSTAT, and byte-lane merge functions.
package disp_regctrl_pkg;

  localparam logic [11:0] OFF_DISPCTRL = 12'h000;
  localparam logic [11:0] OFF_INTCTRL  = 12'h004;
  localparam logic [11:0] OFF_FIFOSTAT = 12'h008;
  localparam logic [11:0] OFF_UPDCTRL  = 12'h00C;
  localparam logic [11:0] OFF_FRAMECNT = 12'h010;
  localparam logic [11:0] OFF_LAYER0   = 12'h100;

  localparam int unsigned LAYER_STRIDE    = 4;
  localparam int unsigned INT_VB_IE       = 0;
  localparam int unsigned INT_VB_CLR      = 1;
  localparam int unsigned INT_FIFO_IE     = 2;
  localparam int unsigned UPD_REQ         = 0;
  localparam int unsigned FIFO_OVER_BASE  = 8;
  localparam int unsigned DISPCTRL_VBLANK = 31;

  // Expand the 4 byte enables into a 32-bit bit mask.
  function automatic logic [31:0] be_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  // Replace only the enabled byte lanes of old with wd.
  function automatic logic [31:0] be_merge(input logic [31:0] old, input logic [31:0] wd,
                                           input logic [3:0] be);
    return (old & ~be_mask(be)) | (wd & be_mask(be));
  endfunction

endpackage

// File: rtl/disp_vsync_edge.sv
// VSYNC synchroniser and falling-edge detector.
//   ACLK, ARST   : clock, synchronous active-high reset
//   vsync_x_i    : active-low VSYNC, asynchronous to ACLK
//   vs_fall_o    : one-cycle pulse, high 3 ACLK edges after the pin falls
module disp_vsync_edge (
  input  logic ACLK,
  input  logic ARST,
  input  logic vsync_x_i,
  output logic vs_fall_o
);

  logic sync1_q, sync2_q, prev_q, fall_q;

  // History flops reset to the inactive level so reset never looks like an edge.
  always_ff @(posedge ACLK) begin
    if (ARST) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= vsync_x_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      fall_q  <= prev_q & ~sync2_q;
    end
  end

  assign vs_fall_o = fall_q;

endmodule

// File: rtl/disp_layer_regctrl.sv
// Multi-layer display register controller.
//   Register bus : WRADDR/BYTEEN/WREN/WDATA writes, RDADDR/RDEN reads, RDATA (1-cycle latency)
//   Display      : DISPON/DISPADDR active values, loaded from shadow on VSYNC fall when armed;
//                  LAYER_UPDATE pulses on the load
//   Status       : BUF_UNDER/BUF_OVER sticky flags, frame counter, DSP_IRQ registered interrupt
module disp_layer_regctrl
  import disp_regctrl_pkg::*;
#(
  parameter int unsigned NLAYER = 2,
  parameter int unsigned ADDR_W = 29,
  parameter logic [3:0]  BLK_ID = 4'h0
) (
  input  logic                     ACLK,
  input  logic                     ARST,
  input  logic                     DSP_VSYNC_X,
  input  logic [15:0]              WRADDR,
  input  logic [3:0]               BYTEEN,
  input  logic                     WREN,
  input  logic [31:0]              WDATA,
  input  logic [15:0]              RDADDR,
  input  logic                     RDEN,
  output logic [31:0]              RDATA,
  output logic [NLAYER-1:0]        DISPON,
  output logic [NLAYER*ADDR_W-1:0] DISPADDR,
  output logic                     LAYER_UPDATE,
  output logic                     DSP_IRQ,
  input  logic [NLAYER-1:0]        BUF_UNDER,
  input  logic [NLAYER-1:0]        BUF_OVER
);

  logic                     vs_fall;
  logic [NLAYER-1:0]        shadow_en_q, shadow_en_d;
  logic [ADDR_W-1:0]        shadow_addr_q [NLAYER];
  logic [ADDR_W-1:0]        shadow_addr_d [NLAYER];
  logic [NLAYER-1:0]        dispon_q, dispon_d;
  logic [NLAYER*ADDR_W-1:0] dispaddr_q, dispaddr_d;
  logic                     updreq_q, updreq_d;
  logic                     vblank_q, vblank_d;
  logic                     ie_vb_q, ie_vb_d;
  logic                     ie_fifo_q, ie_fifo_d;
  logic [NLAYER-1:0]        under_q, under_d;
  logic [NLAYER-1:0]        over_q, over_d;
  logic [15:0]              framecnt_q, framecnt_d;
  logic                     layer_update_q, layer_update_d;
  logic                     irq_q, irq_d;
  logic [31:0]              rdata_q;
  logic [31:0]              rd_val_c;
  logic [31:0]              intctrl_c;
  logic [31:0]              fifostat_c;
  logic                     wr_sel_c;

  disp_vsync_edge u_vsync_edge (
    .ACLK      (ACLK),
    .ARST      (ARST),
    .vsync_x_i (DSP_VSYNC_X),
    .vs_fall_o (vs_fall)
  );

  assign intctrl_c  = (32'(ie_fifo_q) << INT_FIFO_IE) | (32'(ie_vb_q) << INT_VB_IE);
  assign fifostat_c = (32'(over_q) << FIFO_OVER_BASE) | 32'(under_q);
  assign wr_sel_c   = WREN && (WRADDR[15:12] == BLK_ID);

  // Next state: clears and transfers first, then writes, then hardware sets (sets win).
  always_comb begin
    shadow_en_d    = shadow_en_q;
    shadow_addr_d  = shadow_addr_q;
    dispon_d       = dispon_q;
    dispaddr_d     = dispaddr_q;
    updreq_d       = updreq_q;
    vblank_d       = vblank_q;
    ie_vb_d        = ie_vb_q;
    ie_fifo_d      = ie_fifo_q;
    under_d        = under_q;
    over_d         = over_q;
    framecnt_d     = framecnt_q;
    layer_update_d = 1'b0;

    // Transfer uses pre-write shadow values; a same-cycle UPDREQ write re-arms below.
    if (vs_fall) begin
      framecnt_d = framecnt_q + 16'd1;
      if (updreq_q) begin
        dispon_d = shadow_en_q;
        for (int unsigned n = 0; n < NLAYER; n++) begin
          dispaddr_d[n*ADDR_W +: ADDR_W] = shadow_addr_q[n];
        end
        updreq_d       = 1'b0;
        layer_update_d = 1'b1;
      end
    end

    if (wr_sel_c) begin
      case (WRADDR[11:0])
        OFF_DISPCTRL: shadow_en_d = NLAYER'(be_merge(32'(shadow_en_q), WDATA, BYTEEN));
        OFF_INTCTRL: begin
          ie_vb_d   = 1'(be_merge(intctrl_c, WDATA, BYTEEN) >> INT_VB_IE);
          ie_fifo_d = 1'(be_merge(intctrl_c, WDATA, BYTEEN) >> INT_FIFO_IE);
          if (1'(be_merge(32'd0, WDATA, BYTEEN) >> INT_VB_CLR)) vblank_d = 1'b0;
        end
        OFF_FIFOSTAT: begin
          under_d = under_q & ~NLAYER'(be_merge(32'd0, WDATA, BYTEEN));
          over_d  = over_q & ~NLAYER'(be_merge(32'd0, WDATA, BYTEEN) >> FIFO_OVER_BASE);
        end
        OFF_UPDCTRL: if (1'(be_merge(32'd0, WDATA, BYTEEN) >> UPD_REQ)) updreq_d = 1'b1;
        default: begin
          for (int unsigned n = 0; n < NLAYER; n++) begin
            if (WRADDR[11:0] == 12'(OFF_LAYER0 + LAYER_STRIDE * n)) begin
              shadow_addr_d[n] = ADDR_W'(be_merge(32'(shadow_addr_q[n]), WDATA, BYTEEN));
            end
          end
        end
      endcase
    end

    if (vs_fall) vblank_d = 1'b1;
    under_d = under_d | BUF_UNDER;
    over_d  = over_d | BUF_OVER;

    irq_d = (ie_vb_q & vblank_q) | (ie_fifo_q & ((|under_q) | (|over_q)));
  end

  // Read mux; unselected or unmapped reads return 0.
  always_comb begin
    rd_val_c = '0;
    if (RDEN && (RDADDR[15:12] == BLK_ID)) begin
      case (RDADDR[11:0])
        OFF_DISPCTRL: rd_val_c = 32'(shadow_en_q) | (32'(vblank_q) << DISPCTRL_VBLANK);
        OFF_INTCTRL:  rd_val_c = intctrl_c;
        OFF_FIFOSTAT: rd_val_c = fifostat_c;
        OFF_UPDCTRL:  rd_val_c = 32'(updreq_q) << UPD_REQ;
        OFF_FRAMECNT: rd_val_c = 32'(framecnt_q);
        default: begin
          for (int unsigned n = 0; n < NLAYER; n++) begin
            if (RDADDR[11:0] == 12'(OFF_LAYER0 + LAYER_STRIDE * n)) begin
              rd_val_c = 32'(shadow_addr_q[n]);
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARST) begin
      shadow_en_q    <= '0;
      for (int unsigned n = 0; n < NLAYER; n++) shadow_addr_q[n] <= '0;
      dispon_q       <= '0;
      dispaddr_q     <= '0;
      updreq_q       <= 1'b0;
      vblank_q       <= 1'b0;
      ie_vb_q        <= 1'b0;
      ie_fifo_q      <= 1'b0;
      under_q        <= '0;
      over_q         <= '0;
      framecnt_q     <= '0;
      layer_update_q <= 1'b0;
      irq_q          <= 1'b0;
      rdata_q        <= '0;
    end else begin
      shadow_en_q    <= shadow_en_d;
      shadow_addr_q  <= shadow_addr_d;
      dispon_q       <= dispon_d;
      dispaddr_q     <= dispaddr_d;
      updreq_q       <= updreq_d;
      vblank_q       <= vblank_d;
      ie_vb_q        <= ie_vb_d;
      ie_fifo_q      <= ie_fifo_d;
      under_q        <= under_d;
      over_q         <= over_d;
      framecnt_q     <= framecnt_d;
      layer_update_q <= layer_update_d;
      irq_q          <= irq_d;
      rdata_q        <= rd_val_c;
    end
  end

  assign RDATA        = rdata_q;
  assign DISPON       = dispon_q;
  assign DISPADDR     = dispaddr_q;
  assign LAYER_UPDATE = layer_update_q;
  assign DSP_IRQ      = irq_q;

endmodule

// File: tb/tb_disp_layer_regctrl.sv
// Self-checking bench for disp_layer_regctrl (NLAYER=2, ADDR_W=29, BLK_ID=0).
module tb_disp_layer_regctrl;

  logic        ACLK, ARST, DSP_VSYNC_X;
  logic [15:0] WRADDR, RDADDR;
  logic [3:0]  BYTEEN;
  logic        WREN, RDEN;
  logic [31:0] WDATA, RDATA;
  logic [1:0]  DISPON;
  logic [57:0] DISPADDR;
  logic        LAYER_UPDATE, DSP_IRQ;
  logic [1:0]  BUF_UNDER, BUF_OVER;

  int n_checks = 0;
  int n_pass   = 0;

  disp_layer_regctrl #(.NLAYER(2), .ADDR_W(29), .BLK_ID(4'h0)) dut (
    .ACLK(ACLK), .ARST(ARST), .DSP_VSYNC_X(DSP_VSYNC_X),
    .WRADDR(WRADDR), .BYTEEN(BYTEEN), .WREN(WREN), .WDATA(WDATA),
    .RDADDR(RDADDR), .RDEN(RDEN), .RDATA(RDATA),
    .DISPON(DISPON), .DISPADDR(DISPADDR), .LAYER_UPDATE(LAYER_UPDATE),
    .DSP_IRQ(DSP_IRQ), .BUF_UNDER(BUF_UNDER), .BUF_OVER(BUF_OVER)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [15:0] wa;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [15:0] ra;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic wr(input logic [15:0] a, input logic [3:0] be, input logic [31:0] d);
    @(negedge ACLK);
    WRADDR = a; BYTEEN = be; WDATA = d; WREN = 1'b1;
    @(negedge ACLK);
    WREN = 1'b0; WRADDR = '0; BYTEEN = '0; WDATA = '0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [31:0] v);
    @(negedge ACLK);
    RDADDR = a; RDEN = 1'b1;
    @(negedge ACLK);
    v = RDATA; RDEN = 1'b0; RDADDR = '0;
  endtask

  // Pulse VSYNC low for 2 cycles; optionally issue a write landing on the vs_fall cycle.
  task automatic vs_pulse(input logic do_wr, input logic [15:0] a, input logic [3:0] be,
                          input logic [31:0] d, output int upd_cnt, output int upd_at);
    upd_cnt = 0; upd_at = 0;
    @(negedge ACLK);
    DSP_VSYNC_X = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge ACLK);
      WREN = 1'b0;
      if (LAYER_UPDATE) begin upd_cnt++; upd_at = k; end
      if (k == 2) DSP_VSYNC_X = 1'b1;
      if (k == 3 && do_wr) begin
        WRADDR = a; BYTEEN = be; WDATA = d; WREN = 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge ACLK);
    ARST = 1'b1;
    repeat (2) @(negedge ACLK);
    ARST = 1'b0;
  endtask

  logic [31:0] v;
  logic [63:0] exp_addr;
  int uc, ua;

  initial begin
    ARST = 1'b1; DSP_VSYNC_X = 1'b1;
    WRADDR = '0; BYTEEN = '0; WREN = 1'b0; WDATA = '0;
    RDADDR = '0; RDEN = 1'b0; BUF_UNDER = '0; BUF_OVER = '0;

    vecs[0]  = '{16'h0104, 4'b0010, 32'hAABBCCDD, 16'h0104, 32'h0000CC00};
    vecs[1]  = '{16'h0104, 4'b1111, 32'hFFFFFFFF, 16'h0104, 32'h1FFFFFFF};
    vecs[2]  = '{16'h0104, 4'b1000, 32'h00000000, 16'h0104, 32'h00FFFFFF};
    vecs[3]  = '{16'h0000, 4'b0001, 32'hFFFFFFFF, 16'h0000, 32'h00000003};
    vecs[4]  = '{16'h0000, 4'b1110, 32'h00000000, 16'h0000, 32'h00000003};
    vecs[5]  = '{16'h0004, 4'b0001, 32'hFFFFFFFF, 16'h0004, 32'h00000005};
    vecs[6]  = '{16'h0004, 4'b0001, 32'h00000000, 16'h0004, 32'h00000000};
    vecs[7]  = '{16'h0014, 4'b1111, 32'hFFFFFFFF, 16'h0014, 32'h00000000};
    vecs[8]  = '{16'h0108, 4'b1111, 32'hFFFFFFFF, 16'h0108, 32'h00000000};
    vecs[9]  = '{16'h000C, 4'b0000, 32'h00000001, 16'h000C, 32'h00000000};
    vecs[10] = '{16'h0010, 4'b1111, 32'hFFFFFFFF, 16'h0010, 32'h00000000};
    vecs[11] = '{16'h1100, 4'b1111, 32'hDEADBEEF, 16'h0100, 32'h00000000};
    vecs[12] = '{16'h0100, 4'b1111, 32'hDEADBEEF, 16'h1100, 32'h00000000};
    vecs[13] = '{16'h0008, 4'b1111, 32'hFFFFFFFF, 16'h0100, 32'h1EADBEEF};
    vecs[14] = '{16'h0102, 4'b1111, 32'h00000000, 16'h0100, 32'h1EADBEEF};

    repeat (3) @(negedge ACLK);
    ARST = 1'b0;
    @(negedge ACLK);
    chk("rst_rdata", 64'(RDATA), 64'h0);
    chk("rst_dispon", 64'(DISPON), 64'h0);
    chk("rst_dispaddr", 64'(DISPADDR), 64'h0);
    chk("rst_layer_update", 64'(LAYER_UPDATE), 64'h0);
    chk("rst_irq", 64'(DSP_IRQ), 64'h0);

    // Register table
    for (int i = 0; i < 15; i++) begin
      wr(vecs[i].wa, vecs[i].be, vecs[i].wd);
      rd(vecs[i].ra, v);
      chk($sformatf("vec%0d", i), 64'(v), 64'(vecs[i].exp));
    end
    @(negedge ACLK);
    chk("rdata_idle_zero", 64'(RDATA), 64'h0);
    chk("table_irq", 64'(DSP_IRQ), 64'h0);

    do_reset();
    rd(16'h0104, v); chk("rst_shadow1", 64'(v), 64'h0);

    // Shadow writes without UPDREQ do not reach the outputs
    wr(16'h0100, 4'hF, 32'h01234560);
    wr(16'h0000, 4'hF, 32'h00000001);
    vs_pulse(1'b0, '0, '0, '0, uc, ua);
    chk("noarm_upd_cnt", 64'(uc), 64'd0);
    chk("noarm_dispon", 64'(DISPON), 64'h0);
    chk("noarm_dispaddr", 64'(DISPADDR), 64'h0);
    rd(16'h0010, v); chk("noarm_framecnt", 64'(v), 64'd1);
    rd(16'h0000, v); chk("noarm_dispctrl", 64'(v), 64'h80000001);

    // Armed update
    wr(16'h000C, 4'h1, 32'h1);
    rd(16'h000C, v); chk("upd_pending", 64'(v), 64'd1);
    vs_pulse(1'b0, '0, '0, '0, uc, ua);
    chk("arm_upd_cnt", 64'(uc), 64'd1);
    chk("arm_upd_at", 64'(ua), 64'd4);
    chk("arm_dispaddr", 64'(DISPADDR), 64'h01234560);
    chk("arm_dispon", 64'(DISPON), 64'h1);
    rd(16'h000C, v); chk("upd_cleared", 64'(v), 64'd0);
    rd(16'h0010, v); chk("framecnt2", 64'(v), 64'd2);

    // VBLANK interrupt
    wr(16'h0004, 4'h1, 32'h2);
    wr(16'h0004, 4'h1, 32'h1);
    @(negedge ACLK);
    chk("vb_irq_idle", 64'(DSP_IRQ), 64'h0);
    vs_pulse(1'b0, '0, '0, '0, uc, ua);
    chk("vb_irq_set", 64'(DSP_IRQ), 64'h1);
    rd(16'h0000, v); chk("vb_dispctrl", 64'(v), 64'h80000001);
    wr(16'h0004, 4'h1, 32'h3);
    chk("vb_irq_latency", 64'(DSP_IRQ), 64'h1);
    @(negedge ACLK);
    chk("vb_irq_clear", 64'(DSP_IRQ), 64'h0);
    rd(16'h0000, v); chk("vb_cleared", 64'(v), 64'h00000001);
    vs_pulse(1'b1, 16'h0004, 4'h1, 32'h3, uc, ua);
    rd(16'h0000, v); chk("vb_set_wins", 64'(v), 64'h80000001);
    chk("vb_set_wins_irq", 64'(DSP_IRQ), 64'h1);

    // FIFO error flags
    wr(16'h0004, 4'h1, 32'h6);
    @(negedge ACLK);
    chk("fifo_irq_idle", 64'(DSP_IRQ), 64'h0);
    @(negedge ACLK); BUF_OVER = 2'b10;
    @(negedge ACLK); BUF_OVER = 2'b00;
    rd(16'h0008, v); chk("fifo_over1", 64'(v), 64'h200);
    chk("fifo_irq_set", 64'(DSP_IRQ), 64'h1);
    wr(16'h0008, 4'b0010, 32'h200);
    rd(16'h0008, v); chk("fifo_w1c", 64'(v), 64'h0);
    chk("fifo_irq_clear", 64'(DSP_IRQ), 64'h0);
    @(negedge ACLK);
    BUF_OVER = 2'b10;
    WRADDR = 16'h0008; BYTEEN = 4'b0010; WDATA = 32'h200; WREN = 1'b1;
    @(negedge ACLK);
    BUF_OVER = 2'b00; WREN = 1'b0; WRADDR = '0; BYTEEN = '0; WDATA = '0;
    rd(16'h0008, v); chk("fifo_set_wins", 64'(v), 64'h200);
    @(negedge ACLK); BUF_UNDER = 2'b01;
    @(negedge ACLK); BUF_UNDER = 2'b00;
    rd(16'h0008, v); chk("fifo_under0", 64'(v), 64'h201);
    wr(16'h0008, 4'hF, 32'h303);
    rd(16'h0008, v); chk("fifo_clear_all", 64'(v), 64'h0);
    wr(16'h0004, 4'h1, 32'h0);

    // Frame counter wrap
    rd(16'h0010, v); chk("framecnt4", 64'(v), 64'd4);
    @(negedge ACLK);
    force dut.framecnt_q = 16'hFFFE;
    @(negedge ACLK);
    release dut.framecnt_q;
    vs_pulse(1'b0, '0, '0, '0, uc, ua);
    rd(16'h0010, v); chk("framecnt_ffff", 64'(v), 64'hFFFF);
    vs_pulse(1'b0, '0, '0, '0, uc, ua);
    rd(16'h0010, v); chk("framecnt_wrap", 64'(v), 64'h0);

    // Reset discards a pending update
    wr(16'h000C, 4'h1, 32'h1);
    do_reset();
    vs_pulse(1'b0, '0, '0, '0, uc, ua);
    chk("rst_pend_upd_cnt", 64'(uc), 64'd0);
    chk("rst_pend_dispaddr", 64'(DISPADDR), 64'h0);
    rd(16'h000C, v); chk("rst_pend_updctrl", 64'(v), 64'd0);

    // Re-arm on the transfer cycle keeps UPDREQ set
    wr(16'h0100, 4'hF, 32'h0AAAAAA0);
    wr(16'h000C, 4'h1, 32'h1);
    vs_pulse(1'b1, 16'h000C, 4'h1, 32'h1, uc, ua);
    chk("rearm_upd_cnt", 64'(uc), 64'd1);
    chk("rearm_dispaddr", 64'(DISPADDR), 64'h0AAAAAA0);
    rd(16'h000C, v); chk("rearm_updctrl", 64'(v), 64'd1);

    // Shadow write on the transfer cycle: pre-write value goes active
    wr(16'h0100, 4'hF, 32'h05555550);
    wr(16'h0104, 4'hF, 32'h10000004);
    wr(16'h0000, 4'h1, 32'h3);
    vs_pulse(1'b1, 16'h0100, 4'hF, 32'h00000BB0, uc, ua);
    exp_addr = {6'b0, 29'h10000004, 29'h05555550};
    chk("race_dispaddr", 64'(DISPADDR), exp_addr);
    chk("race_dispon", 64'(DISPON), 64'h3);
    rd(16'h0100, v); chk("race_shadow", 64'(v), 64'h00000BB0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
